note_chart_reader: RTL and testbench

Consumes the paused-aware 10 ms `song_time` count and walks the song's note chart ROM in order. It emits each note record to the lane renderer once the record falls inside a fixed lookahead window, so notes spawn early enough to scroll down the highway. It sits between the song timer and the display/scoring pipeline. It is the reader of the timeline the timer writes.

---
 rtl/note_chart_reader.sv | 133 +++++++++++++
 tb/tb_note_chart_reader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/note_chart_reader.sv
// Walks the note chart ROM in order and offers each record to the lane renderer
// once song_time + LEAD reaches its timestamp; zero-lane records are skipped.
module note_chart_reader #(
  parameter int TIME_W = 16,
  parameter int LANES  = 5,
  parameter int ADDR_W = 12,
  parameter int LEAD   = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  song_start,
  input  logic [TIME_W-1:0]     song_time,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [TIME_W+LANES:0] rom_data,
  output logic                  note_valid,
  input  logic                  note_ready,
  output logic [TIME_W-1:0]     note_time,
  output logic [LANES-1:0]      note_lanes,
  output logic                  note_late,
  output logic                  busy,
  output logic                  song_done
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LOAD, S_HOLD, S_EMIT, S_DONE} state_t;

  localparam logic [TIME_W:0] LEAD_X = (TIME_W+1)'(LEAD);

  state_t                r_state, w_state_nxt;
  logic [ADDR_W-1:0]     r_rom_addr;
  logic [TIME_W+LANES:0] r_hold;
  logic                  r_note_valid;
  logic [TIME_W-1:0]     r_note_time;
  logic [LANES-1:0]      r_note_lanes;
  logic                  r_note_late;

  logic                  w_end, w_skip, w_due, w_late, w_last, w_xfer;
  logic [LANES-1:0]      w_lanes;
  logic [TIME_W-1:0]     w_ts;
  logic [TIME_W:0]       w_sum;

  assign w_end   = r_hold[TIME_W+LANES];
  assign w_lanes = r_hold[TIME_W+LANES-1:TIME_W];
  assign w_ts    = r_hold[TIME_W-1:0];
  assign w_skip  = (w_lanes == '0);
  // One extra bit so song_time near the top of the range cannot wrap the window.
  assign w_sum   = {1'b0, song_time} + LEAD_X;
  assign w_due   = (w_sum >= {1'b0, w_ts});
  assign w_late  = (w_ts < song_time);
  assign w_last  = &r_rom_addr;
  assign w_xfer  = r_note_valid & note_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; song_start beats everything, including a handshake
  always_comb begin
    w_state_nxt = r_state;
    if (song_start) begin
      w_state_nxt = S_ADDR;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        S_ADDR: w_state_nxt = S_LOAD;
        S_LOAD: w_state_nxt = S_HOLD;
        S_HOLD: begin
          if (w_end)       w_state_nxt = S_DONE;
          else if (w_skip) w_state_nxt = w_last ? S_DONE : S_ADDR;
          else if (w_due)  w_state_nxt = S_EMIT;
        end
        S_EMIT: if (w_xfer) w_state_nxt = w_last ? S_DONE : S_ADDR;
        S_DONE: w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    busy      = 1'b0;
    song_done = 1'b0;
    case (r_state)
      S_ADDR, S_LOAD, S_HOLD, S_EMIT: busy = 1'b1;
      S_DONE:                         song_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: ROM address, hold register and the registered note outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rom_addr   <= '0;
      r_hold       <= '0;
      r_note_valid <= 1'b0;
      r_note_time  <= '0;
      r_note_lanes <= '0;
      r_note_late  <= 1'b0;
    end else if (song_start) begin
      r_rom_addr   <= '0;
      r_note_valid <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: r_hold <= rom_data;
        S_HOLD: begin
          if (!w_end && w_skip) begin
            if (!w_last) r_rom_addr <= r_rom_addr + ADDR_W'(1);
          end else if (!w_end && w_due) begin
            r_note_valid <= 1'b1;
            r_note_time  <= w_ts;
            r_note_lanes <= w_lanes;
            r_note_late  <= w_late;
          end
        end
        S_EMIT: begin
          if (w_xfer) begin
            r_note_valid <= 1'b0;
            if (!w_last) r_rom_addr <= r_rom_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_addr   = r_rom_addr;
  assign note_valid = r_note_valid;
  assign note_time  = r_note_time;
  assign note_lanes = r_note_lanes;
  assign note_late  = r_note_late;

endmodule

// File: tb/tb_note_chart_reader.sv
// Scoreboard bench for note_chart_reader: directed scenarios push expected notes,
// a negedge monitor pops and compares on every handshake.
module tb_note_chart_reader;
  localparam int TW = 16;
  localparam int LN = 5;
  localparam int AW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            song_start = 1'b0;
  logic [TW-1:0]   song_time = '0;
  logic [AW-1:0]   rom_addr;
  logic [TW+LN:0]  rom_data;
  logic            note_valid;
  logic            note_ready = 1'b0;
  logic [TW-1:0]   note_time;
  logic [LN-1:0]   note_lanes;
  logic            note_late;
  logic            busy;
  logic            song_done;

  logic [TW+LN:0]  rom [4];

  typedef struct {
    logic [TW-1:0] t;
    logic [LN-1:0] l;
    logic          late;
  } exp_t;
  exp_t q[$];

  int n_pass = 0;
  int n_tot  = 0;

  note_chart_reader #(.TIME_W(TW), .LANES(LN), .ADDR_W(AW), .LEAD(200)) dut (
    .clk(clk), .reset(reset), .song_start(song_start), .song_time(song_time),
    .rom_addr(rom_addr), .rom_data(rom_data), .note_valid(note_valid),
    .note_ready(note_ready), .note_time(note_time), .note_lanes(note_lanes),
    .note_late(note_late), .busy(busy), .song_done(song_done)
  );

  always #5 clk = ~clk;

  // Registered chart ROM: data follows the address by one edge
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [TW+LN:0] rec(input logic e, input logic [LN-1:0] l, input logic [TW-1:0] t);
    return {e, l, t};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [TW-1:0] t, input logic [LN-1:0] l, input logic late);
    exp_t e;
    e.t = t; e.l = l; e.late = late;
    q.push_back(e);
  endtask

  task automatic start_pulse();
    song_start = 1'b1;
    tick(1);
    song_start = 1'b0;
  endtask

  // Monitor: every accepted note must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && !song_start && note_valid && note_ready) begin
      if (q.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_note: got t=%0h lanes=%0h with nothing expected", note_time, note_lanes);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("note_time", 32'(note_time), 32'(e.t));
        chk("note_lanes", 32'(note_lanes), 32'(e.l));
        chk("note_late", 32'(note_late), 32'(e.late));
      end
    end
  end

  initial begin
    bit stable, saw_nz, wrapped;
    for (int i = 0; i < 4; i++) rom[i] = rec(1'b1, '0, '0);

    // Reset state
    tick(3);
    reset = 1'b0;
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_valid", 32'(note_valid), 0);
    chk("rst_time", 32'(note_time), 0);
    chk("rst_lanes", 32'(note_lanes), 0);
    chk("rst_late", 32'(note_late), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(song_done), 0);

    // Basic spawn: t=300 due once song_time reaches 100
    rom[0] = rec(1'b0, 5'b00001, 16'd300);
    rom[1] = rec(1'b1, '0, '0);
    song_time = 16'd0; note_ready = 1'b1;
    start_pulse();
    chk("spawn_busy", 32'(busy), 1);
    chk("spawn_addr0", 32'(rom_addr), 0);
    tick(10);
    chk("spawn_wait0", 32'(note_valid), 0);
    song_time = 16'd99;
    tick(2);
    chk("spawn_wait99", 32'(note_valid), 0);
    push(16'd300, 5'b00001, 1'b0);
    song_time = 16'd100;
    tick(1);
    chk("spawn_valid", 32'(note_valid), 1);
    tick(1);
    tick(2);
    chk("spawn_done_m2", 32'(song_done), 0);
    tick(1);
    chk("spawn_done_m3", 32'(song_done), 1);
    chk("spawn_idle_busy", 32'(busy), 0);

    // Backpressure: two due records, renderer stalls 20 cycles
    rom[0] = rec(1'b0, 5'b00011, 16'd10);
    rom[1] = rec(1'b0, 5'b00100, 16'd10);
    rom[2] = rec(1'b1, '0, '0);
    song_time = 16'd0; note_ready = 1'b0;
    push(16'd10, 5'b00011, 1'b0);
    push(16'd10, 5'b00100, 1'b0);
    start_pulse();
    tick(2);
    chk("bp_k2_valid", 32'(note_valid), 0);
    tick(1);
    chk("bp_k3_valid", 32'(note_valid), 1);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!(note_valid === 1'b1 && note_time === 16'd10 && note_lanes === 5'b00011)) stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 1);
    note_ready = 1'b1;
    tick(1);
    chk("bp_m_valid", 32'(note_valid), 0);
    tick(2);
    chk("bp_m2_valid", 32'(note_valid), 0);
    tick(1);
    chk("bp_m3_valid", 32'(note_valid), 1);
    chk("bp_m3_lanes", 32'(note_lanes), 32'h04);
    tick(8);
    chk("bp_done", 32'(song_done), 1);

    // Skip zero-lane record, second one is late
    rom[0] = rec(1'b0, 5'b00000, 16'd5);
    rom[1] = rec(1'b0, 5'b10010, 16'd50);
    rom[2] = rec(1'b1, '0, '0);
    song_time = 16'd400; note_ready = 1'b1;
    push(16'd50, 5'b10010, 1'b1);
    start_pulse();
    tick(12);
    chk("skip_done", 32'(song_done), 1);
    chk("skip_addr", 32'(rom_addr), 2);

    // Overflow: due test must not wrap near the top of the time range
    rom[0] = rec(1'b0, 5'b00001, 16'hFFF0);
    rom[1] = rec(1'b1, '0, '0);
    song_time = 16'h0000;
    start_pulse();
    tick(10);
    chk("ovf_t0_valid", 32'(note_valid), 0);
    chk("ovf_t0_busy", 32'(busy), 1);
    song_time = 16'hFF00;
    tick(3);
    chk("ovf_ff00_valid", 32'(note_valid), 0);
    push(16'hFFF0, 5'b00001, 1'b0);
    song_time = 16'hFFE0;
    tick(1);
    chk("ovf_ffe0_valid", 32'(note_valid), 1);
    tick(8);
    chk("ovf_done", 32'(song_done), 1);

    // Restart mid-EMIT, and restart coinciding with a handshake
    rom[0] = rec(1'b0, 5'b00010, 16'd10);
    rom[1] = rec(1'b1, '0, '0);
    song_time = 16'd0; note_ready = 1'b0;
    start_pulse();
    chk("rs_done_clr", 32'(song_done), 0);
    tick(3);
    chk("rs_valid", 32'(note_valid), 1);
    start_pulse();
    chk("rs_abort_valid", 32'(note_valid), 0);
    chk("rs_abort_addr", 32'(rom_addr), 0);
    chk("rs_abort_busy", 32'(busy), 1);
    tick(2);
    chk("rs_r2_valid", 32'(note_valid), 0);
    tick(1);
    chk("rs_r3_valid", 32'(note_valid), 1);
    note_ready = 1'b1; song_start = 1'b1;
    tick(1);
    song_start = 1'b0; note_ready = 1'b0;
    chk("rs_prio_valid", 32'(note_valid), 0);
    chk("rs_prio_addr", 32'(rom_addr), 0);
    push(16'd10, 5'b00010, 1'b0);
    note_ready = 1'b1;
    tick(10);
    chk("rs_done", 32'(song_done), 1);

    // Reset mid-EMIT, then reset together with song_start
    rom[0] = rec(1'b0, 5'b00000, 16'd0);
    rom[1] = rec(1'b0, 5'b00111, 16'd20);
    rom[2] = rec(1'b1, '0, '0);
    note_ready = 1'b0;
    start_pulse();
    tick(6);
    chk("rr_valid", 32'(note_valid), 1);
    chk("rr_addr1", 32'(rom_addr), 1);
    reset = 1'b1;
    tick(1);
    chk("rr_valid0", 32'(note_valid), 0);
    chk("rr_time0", 32'(note_time), 0);
    chk("rr_lanes0", 32'(note_lanes), 0);
    chk("rr_late0", 32'(note_late), 0);
    chk("rr_addr0", 32'(rom_addr), 0);
    chk("rr_busy0", 32'(busy), 0);
    song_start = 1'b1;
    tick(1);
    chk("rr_both_busy", 32'(busy), 0);
    reset = 1'b0; song_start = 1'b0;
    tick(5);
    chk("rr_idle_busy", 32'(busy), 0);
    chk("rr_idle_valid", 32'(note_valid), 0);

    // Address wrap: four notes, no end marker
    for (int i = 0; i < 4; i++) begin
      rom[i] = rec(1'b0, 5'(1 << i), 16'(i + 1));
      push(16'(i + 1), 5'(1 << i), 1'b0);
    end
    song_time = 16'd0; note_ready = 1'b1;
    start_pulse();
    saw_nz = 1'b0; wrapped = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (rom_addr != '0) saw_nz = 1'b1;
      else if (saw_nz) wrapped = 1'b1;
    end
    chk("wrap_no_return", 32'(wrapped), 0);
    chk("wrap_done", 32'(song_done), 1);
    chk("wrap_addr", 32'(rom_addr), 3);

    chk("sb_empty", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
